// File: rtl/sram_ws_arbiter.sv
// rtl/sram_ws_arbiter.sv - three-master round-robin arbiter in front of the SRAM Wishbone wrapper
module sram_ws_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic         clkCPU,
   input  logic         rst_n,
   input  logic [31:0]  m0_addr,
   input  logic [767:0] m0_din,
   input  logic [95:0]  m0_dm,
   input  logic         m0_we,
   input  logic         m0_stb,
   output logic         m0_ack,
   input  logic [31:0]  m1_addr,
   input  logic [767:0] m1_din,
   input  logic [95:0]  m1_dm,
   input  logic         m1_we,
   input  logic         m1_stb,
   output logic         m1_ack,
   input  logic [31:0]  m2_addr,
   input  logic [767:0] m2_din,
   input  logic [95:0]  m2_dm,
   input  logic         m2_we,
   input  logic         m2_stb,
   output logic         m2_ack,
   output logic [767:0] m_dout,
   output logic [31:0]  s_addr,
   output logic [767:0] s_din,
   output logic [95:0]  s_dm,
   output logic         s_we,
   output logic         s_stb,
   input  logic         s_ack,
   input  logic [767:0] s_dout,
   output logic [2:0]   grant,
   output logic         err
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   // Counter value seen during the last in-budget WAIT cycle
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nx;
   logic [1:0]    last;
   logic [2:0]    req;
   logic [2:0]    win;
   logic [1:0]    win_idx;
   logic [15:0]   cnt;
   logic [31:0]   sel_addr;
   logic [767:0]  sel_din;
   logic [95:0]   sel_dm;
   logic          sel_we;

   assign req = {m2_stb, m1_stb, m0_stb};

   // Round-robin pick: search begins at the master after the previous owner
   always_comb begin
      win     = 3'b000;
      win_idx = 2'd0;
      case (last)
         2'd0: begin
            if (req[1])      begin win = 3'b010; win_idx = 2'd1; end
            else if (req[2]) begin win = 3'b100; win_idx = 2'd2; end
            else if (req[0]) begin win = 3'b001; win_idx = 2'd0; end
         end
         2'd1: begin
            if (req[2])      begin win = 3'b100; win_idx = 2'd2; end
            else if (req[0]) begin win = 3'b001; win_idx = 2'd0; end
            else if (req[1]) begin win = 3'b010; win_idx = 2'd1; end
         end
         default: begin
            if (req[0])      begin win = 3'b001; win_idx = 2'd0; end
            else if (req[1]) begin win = 3'b010; win_idx = 2'd1; end
            else if (req[2]) begin win = 3'b100; win_idx = 2'd2; end
         end
      endcase
   end

   // Request fields of the winning master
   always_comb begin
      sel_addr = m0_addr;
      sel_din  = m0_din;
      sel_dm   = m0_dm;
      sel_we   = m0_we;
      if (win[1]) begin
         sel_addr = m1_addr;
         sel_din  = m1_din;
         sel_dm   = m1_dm;
         sel_we   = m1_we;
      end else if (win[2]) begin
         sel_addr = m2_addr;
         sel_din  = m2_din;
         sel_dm   = m2_dm;
         sel_we   = m2_we;
      end
   end

   // State register
   always_ff @(posedge clkCPU or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: a transaction is never aborted, only an ack returns to IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (|req) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (s_ack) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Latch the winner, hold ownership until ack, count WAIT cycles, raise sticky timeout
   always_ff @(posedge clkCPU or negedge rst_n) begin
      if (!rst_n) begin
         last   <= 2'd2;
         grant  <= 3'b000;
         s_addr <= '0;
         s_din  <= '0;
         s_dm   <= '0;
         s_we   <= 1'b0;
         cnt    <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  s_addr <= sel_addr;
                  s_din  <= sel_din;
                  s_dm   <= sel_dm;
                  s_we   <= sel_we;
                  grant  <= win;
                  last   <= win_idx;
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
               if (!s_ack && cnt >= CNT_LAST) err <= 1'b1;
               if (s_ack) grant <= 3'b000;
            end
            default: ;
         endcase
      end
   end

   // Strobe is a decode of the one-cycle ISSUE state, so it can never repeat back to back
   assign s_stb = (state == ISSUE);

   // Acks only count in WAIT; a stray wrapper ack in IDLE or ISSUE is dropped
   assign m0_ack = s_ack & grant[0] & (state == WAIT);
   assign m1_ack = s_ack & grant[1] & (state == WAIT);
   assign m2_ack = s_ack & grant[2] & (state == WAIT);
   assign m_dout = s_dout;

endmodule

// File: tb/tb_sram_ws_arbiter.sv
// tb/tb_sram_ws_arbiter.sv - self-checking bench for sram_ws_arbiter
module tb_sram_ws_arbiter;

   localparam int TO = 8;

   logic          clkCPU;
   logic          rst_n;
   logic [31:0]   ma   [0:2];
   logic [767:0]  md   [0:2];
   logic [95:0]   mdm  [0:2];
   logic          mwe  [0:2];
   logic          mstb [0:2];
   logic [2:0]    mack;
   logic [767:0]  m_dout;
   logic [31:0]   s_addr;
   logic [767:0]  s_din;
   logic [95:0]   s_dm;
   logic          s_we;
   logic          s_stb;
   logic          s_ack;
   logic [767:0]  s_dout;
   logic [2:0]    grant;
   logic          err;

   sram_ws_arbiter #(.TIMEOUT(TO)) dut (
      .clkCPU(clkCPU), .rst_n(rst_n),
      .m0_addr(ma[0]), .m0_din(md[0]), .m0_dm(mdm[0]), .m0_we(mwe[0]), .m0_stb(mstb[0]), .m0_ack(mack[0]),
      .m1_addr(ma[1]), .m1_din(md[1]), .m1_dm(mdm[1]), .m1_we(mwe[1]), .m1_stb(mstb[1]), .m1_ack(mack[1]),
      .m2_addr(ma[2]), .m2_din(md[2]), .m2_dm(mdm[2]), .m2_we(mwe[2]), .m2_stb(mstb[2]), .m2_ack(mack[2]),
      .m_dout(m_dout), .s_addr(s_addr), .s_din(s_din), .s_dm(s_dm), .s_we(s_we), .s_stb(s_stb),
      .s_ack(s_ack), .s_dout(s_dout), .grant(grant), .err(err)
   );

   int checks = 0;
   int errors = 0;

   // stimulus / wrapper model state
   int           cyc = 0;
   int           req_left [0:2];
   int           seq [0:2];
   bit           auto_mode;
   int           lat;
   bit           stray_req;
   logic [767:0] rd_line;
   int           nacks;
   int           nstb_w;
   bit           pending;
   int           due;
   logic [2:0]   ack_seen;
   bit           stb_seen;

   // reference model state
   int           owner;
   int           s_cyc;
   int           last_m;
   bit           err_m;
   logic [31:0]  e_addr;
   logic [767:0] e_din;
   logic [95:0]  e_dm;
   logic         e_we;
   int           w;
   logic [2:0]   exp_ack;
   logic [2:0]   exp_g;
   bit           set_err;

   // observations for the hand-computed expectations
   int           n_stb, n_mack, n_sack, stb_at, ack_at, err_rise_at, consec;
   logic [31:0]  cap_addr;
   logic         cap_we;
   logic [767:0] cap_din;
   logic [95:0]  cap_dm;
   logic [767:0] cap_dout;
   bit           prev_stb, prev_err;
   int           gq [$];
   int           exp_rr [4];

   initial begin
      clkCPU = 1'b0;
      forever #5 clkCPU = ~clkCPU;
   end

   task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic gen(input int n);
      ma[n]  = 32'(32'h0001_0000 * (n + 1) + seq[n] * 64);
      md[n]  = {24{$urandom()}};
      mdm[n] = {3{$urandom()}};
      mwe[n] = (seq[n] % 2 == 1);
   endtask

   // Masters hold their request until acked; wrapper acks `lat` cycles after each strobe
   initial begin
      s_ack = 1'b0;
      s_dout = '0;
      pending = 0;
      for (int n = 0; n < 3; n++) mstb[n] = 1'b0;
      forever begin
         @(posedge clkCPU);
         cyc++;
         #1;
         for (int n = 0; n < 3; n++) begin
            if (ack_seen[n]) begin
               if (req_left[n] > 0) req_left[n]--;
               seq[n]++;
               if (auto_mode) gen(n);
            end
            mstb[n] = (req_left[n] > 0);
         end
         if (stb_seen) begin
            pending = 1;
            due = cyc - 1 + (auto_mode ? 1 + (nstb_w % 7) : lat);
            nstb_w++;
         end
         if (pending && cyc == due) begin
            s_ack = 1'b1;
            s_dout = rd_line ^ {24{32'(nacks)}};
            nacks++;
            pending = 0;
         end else begin
            s_ack = stray_req;
            s_dout = '0;
         end
         stray_req = 0;
      end
   end

   // Cycle-by-cycle comparison against the transaction-level model
   initial begin
      owner = -1; last_m = 2; err_m = 0; prev_stb = 0; prev_err = 0;
      forever begin
         @(negedge clkCPU);
         if (!rst_n) begin
            owner = -1; last_m = 2; err_m = 0;
            chk("rst_grant", grant, 3'b000);
            chk("rst_stb", s_stb, 1'b0);
            chk("rst_we", s_we, 1'b0);
            chk("rst_addr", s_addr, 32'h0);
            chk("rst_din", s_din, '0);
            chk("rst_dm", s_dm, 96'h0);
            chk("rst_err", err, 1'b0);
            chk("rst_ack", mack, 3'b000);
         end else begin
            exp_ack = 3'b000;
            set_err = 0;
            if (owner < 0) begin
               chk("idle_grant", grant, 3'b000);
               chk("idle_stb", s_stb, 1'b0);
               w = -1;
               for (int k = 1; k <= 3; k++)
                  if (w < 0 && mstb[(last_m + k) % 3]) w = (last_m + k) % 3;
               if (w >= 0) begin
                  owner = w; s_cyc = cyc + 1; last_m = w;
                  e_addr = ma[w]; e_din = md[w]; e_dm = mdm[w]; e_we = mwe[w];
               end
            end else begin
               exp_g = 3'b001 << owner;
               chk("grant", grant, exp_g);
               chk("stb", s_stb, cyc == s_cyc);
               chk("addr", s_addr, e_addr);
               chk("din", s_din, e_din);
               chk("dm", s_dm, e_dm);
               chk("we", s_we, e_we);
               if (s_ack && cyc > s_cyc) exp_ack = exp_g;
               if (cyc - s_cyc == TO && exp_ack == 3'b000) set_err = 1;
            end
            chk("ack", mack, exp_ack);
            chk("dout", m_dout, s_dout);
            chk("err", err, err_m);
            if (set_err) err_m = 1;
            if (exp_ack != 3'b000) owner = -1;
         end
         if (s_stb) begin
            n_stb++; stb_at = cyc;
            cap_addr = s_addr; cap_we = s_we; cap_din = s_din; cap_dm = s_dm;
            gq.push_back(int'(grant));
            if (prev_stb) consec++;
         end
         if (mack != 3'b000) begin n_mack++; ack_at = cyc; cap_dout = m_dout; end
         if (s_ack) n_sack++;
         if (err && !prev_err) err_rise_at = cyc;
         prev_stb = s_stb; prev_err = err;
         ack_seen = mack; stb_seen = s_stb;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clkCPU);
         #2;
      end
   endtask

   task automatic clear_obs();
      n_stb = 0; n_mack = 0; n_sack = 0; consec = 0;
      stb_at = 0; ack_at = 0; err_rise_at = -1;
      gq.delete();
   endtask

   task automatic do_reset();
      tick(1);
      rst_n = 1'b0;
      for (int n = 0; n < 3; n++) req_left[n] = 0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_done(input string name, input int bound);
      int k;
      k = 0;
      while ((req_left[0] + req_left[1] + req_left[2]) != 0 && k < bound) begin
         tick(1);
         k++;
      end
      chk(name, k < bound, 1'b1);
      tick(3);
   endtask

   initial begin
      rst_n = 1'b0;
      auto_mode = 0; stray_req = 0; lat = 4; rd_line = '0; nacks = 0; nstb_w = 0;
      ack_seen = 3'b000; stb_seen = 0;
      for (int n = 0; n < 3; n++) begin
         req_left[n] = 0; seq[n] = 0;
         ma[n] = '0; md[n] = '0; mdm[n] = '0; mwe[n] = 1'b0;
      end
      clear_obs();
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("reset_err_low", err, 1'b0);
      chk("reset_grant_idle", grant, 3'b000);

      // single read, wrapper latency 40
      clear_obs();
      ma[0] = 32'h100; mwe[0] = 1'b0; md[0] = {24{32'h12345678}}; mdm[0] = '0;
      rd_line = {96{8'hA5}}; nacks = 0; lat = 40;
      req_left[0] = 1;
      wait_done("rd_done", 200);
      chk("rd_stb_count", n_stb, 1);
      chk("rd_addr", cap_addr, 32'h100);
      chk("rd_we", cap_we, 1'b0);
      chk("rd_ack_count", n_mack, 1);
      chk("rd_latency", ack_at - stb_at, 40);
      chk("rd_dout", cap_dout, {96{8'hA5}});
      chk("rd_err_raised", err, 1'b1);
      chk("rd_grant_after", grant, 3'b000);

      // round robin with M0 re-requesting during M1
      do_reset();
      clear_obs();
      for (int n = 0; n < 3; n++) begin
         ma[n] = 32'h1000 * (n + 1); md[n] = {24{32'h0F0F0000 + n}}; mdm[n] = {12{8'h3C}}; mwe[n] = (n == 1);
      end
      rd_line = {24{32'hC0DE0000}}; lat = 5;
      req_left[0] = 1; req_left[1] = 1; req_left[2] = 1;
      for (int k = 0; k < 100 && gq.size() < 2; k++) tick(1);
      chk("rr_second_grant_seen", gq.size() >= 2, 1'b1);
      req_left[0] = 1;
      wait_done("rr_done", 300);
      exp_rr = '{1, 2, 4, 1};
      chk("rr_count", gq.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr_grant%0d", i), (i < gq.size()) ? gq[i] : -1, exp_rr[i]);

      // write path
      clear_obs();
      lat = 6; ma[1] = 32'h2000; mwe[1] = 1'b1; mdm[1] = '1; md[1] = {24{32'hDEADBEEF}};
      req_left[1] = 1;
      wait_done("wr_done", 100);
      chk("wr_we", cap_we, 1'b1);
      chk("wr_addr", cap_addr, 32'h2000);
      chk("wr_din", cap_din, {24{32'hDEADBEEF}});
      chk("wr_dm", cap_dm, {96{1'b1}});
      chk("wr_ack_count", n_mack, 1);
      chk("wr_latency", ack_at - stb_at, 6);

      // timeout: budget 8, wrapper answers after 20
      do_reset();
      chk("to_err_cleared", err, 1'b0);
      clear_obs();
      lat = 20; ma[0] = 32'h300; mwe[0] = 1'b0;
      req_left[0] = 1;
      wait_done("to_done", 100);
      chk("to_err_rise", err_rise_at - stb_at, TO + 1);
      chk("to_ack_latency", ack_at - stb_at, 20);
      chk("to_ack_count", n_mack, 1);
      tick(5);
      chk("to_err_persist", err, 1'b1);

      // stray ack while idle
      clear_obs();
      stray_req = 1;
      tick(4);
      chk("stray_acks", n_mack, 0);
      chk("stray_stb", n_stb, 0);
      chk("stray_grant", grant, 3'b000);

      // reset during WAIT, wrapper acks after reset
      clear_obs();
      lat = 15; ma[2] = 32'h400; mwe[2] = 1'b0;
      req_left[2] = 1;
      for (int k = 0; k < 20 && n_stb < 1; k++) tick(1);
      chk("late_stb_issued", n_stb, 1);
      tick(3);
      rst_n = 1'b0;
      for (int n = 0; n < 3; n++) req_left[n] = 0;
      tick(2);
      rst_n = 1'b1;
      clear_obs();
      tick(20);
      chk("late_ack_none", n_mack, 0);
      chk("late_stb_none", n_stb, 0);
      chk("late_grant", grant, 3'b000);
      chk("late_err", err, 1'b0);
      chk("late_addr", s_addr, 32'h0);

      // strobe hygiene under continuous load
      do_reset();
      clear_obs();
      auto_mode = 1;
      for (int n = 0; n < 3; n++) begin seq[n] = 0; gen(n); end
      req_left[0] = 17; req_left[1] = 17; req_left[2] = 16;
      wait_done("stress_done", 3000);
      auto_mode = 0;
      chk("stress_stb_count", n_stb, 50);
      chk("stress_ack_count", n_mack, 50);
      chk("stress_sack_eq_mack", n_sack, n_mack);
      chk("stress_no_back_to_back", consec, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_ws_arbiter.md
# sram_ws_arbiter

Three-master round-robin arbiter that shares the single SRAM Wishbone slave wrapper (768-bit line port: 16 beats × 48 bits) between the data cache (M0), the instruction cache (M1) and the VGA/DMA line fetcher (M2). It registers the winning request and drives the wrapper with a single-cycle strobe. It routes the wrapper's one-cycle acknowledge back to the winner, and flags transactions that exceed a cycle budget. It sits between the cache/DMA line-fill ports and the SRAM wrapper on the SWORD4 platform.

## Interface
- TIMEOUT, 1024: max cycles from strobe to s_ack before err is raised; range 2..65535.
- clkCPU  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mN_addr  in  32  byte address of line, N = 0,1,2.
- mN_din  in  768  write line, N = 0,1,2.
- mN_dm  in  96  write byte mask, 6 bits per beat, N = 0,1,2.
- mN_we  in  1  1 = write, 0 = read, N = 0,1,2.
- mN_stb  in  1  request; held high with fields stable until mN_ack, N = 0,1,2.
- mN_ack  out  1  one-cycle completion pulse to the granted master, N = 0,1,2.
- m_dout  out  768  read line, shared by all masters; valid only while the matching mN_ack is high.
- s_addr  out  32  to wrapper ws_addr.
- s_din  out  768  to wrapper ws_din.
- s_dm  out  96  to wrapper ws_dm.
- s_we  out  1  to wrapper ws_we.
- s_stb  out  1  to wrapper ws_stb; exactly one cycle per transaction.
- s_ack  in  1  from wrapper ws_ack.
- s_dout  in  768  from wrapper ws_dout.
- grant  out  3  one-hot current owner; 0 when idle.
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any mN_stb is high, pick the winner round-robin, starting from the master after `last` and wrapping 2→0.
  - Latch the winner's addr/din/dm/we into the s_* registers, set grant and `last`, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE: s_stb=1 for this cycle only. Clear the timeout counter and go to WAIT.
- WAIT:
  - s_stb=0 and the s_* fields are held. The counter increments each cycle and saturates.
  - When s_ack=1, the granted mN_ack is high in that same cycle (combinational s_ack & grant[N]), m_dout = s_dout, grant is cleared on the next edge, and the next state is IDLE.
  - When the counter reaches TIMEOUT, set err. The FSM keeps waiting and is never aborted, because the wrapper cannot be cancelled.
- s_stb must never be high in consecutive cycles. A held strobe makes the wrapper restart in its ack cycle.
- A stray s_ack in IDLE or ISSUE (e.g. wrapper finishing a pre-reset transaction) is ignored: no mN_ack and no state change.
- Requests not granted stay pending. Their mN_stb is sampled again at the next IDLE.
- A master that drops mN_stb before ack (a protocol violation) does not cancel the transaction. The ack is still delivered.
- m_dout is a pure pass-through of s_dout. The wrapper zeroes s_dout after its ack cycle, so data is not held.

## Timing
- Reset values: state IDLE, `last`=2 (so M0 has first priority), grant=0, s_stb=0, s_we=0, s_addr/s_din/s_dm=0, err=0, counter=0, all mN_ack=0.
- Request sampled in IDLE at edge t: s_stb is high during cycle t+1 and grant is valid from t+1.
- Completion: mN_ack coincides with s_ack. Arbiter overhead is 2 cycles plus wrapper latency.
- Back-to-back: after the ack cycle the FSM is in IDLE. A new strobe issues no earlier than 2 cycles after the previous s_ack, which is the wrapper's READY window.
- Simultaneous requests resolve in the same IDLE cycle. A requester that deasserts in the cycle after its ack is never re-granted.
- Reset asserted mid-transaction forces IDLE immediately. The later wrapper ack falls under the stray-ack rule.

## Test plan
- Single read: M0 reads addr 0x100 and the wrapper model acks after 40 cycles with s_dout=0xA5… → s_stb high exactly 1 cycle with s_addr=0x100 and s_we=0; m0_ack pulses in the s_ack cycle with m_dout=0xA5…; grant=001 during WAIT, then 000.
- Round-robin: M0, M1 and M2 request at the same cycle after reset → grants M0, M1, M2 in order. M0 re-requests during M1's transaction and is served after M2.
- Write path: M1 writes addr 0x2000 with dm=96'hFFF…F and a fixed din pattern → s_we=1 and s_din/s_dm equal the inputs, held stable until s_ack; m1_ack is 1 cycle.
- Timeout: TIMEOUT=8 and the model acks after 20 cycles → err rises at the 8th WAIT cycle and stays high. m0_ack still arrives at cycle 20, and err persists after completion.
- Stray ack: s_ack pulsed while idle → no mN_ack and state stays IDLE. Reset during WAIT, then a late s_ack → all outputs at reset values and no ack delivered.
- Strobe hygiene: continuous requests from all three masters for 50 transactions → s_stb is never high in two consecutive cycles and the s_ack count equals the mN_ack count.
